// File: rtl/nibble_bus_arbiter.sv
// Round-robin arbiter for the shared 8-to-1 nibble mux: grants one requester at a time,
// bounds each ownership to MAX_HOLD cycles and optionally inserts GAP_CYCLES idle cycles.
module nibble_bus_arbiter #(
  parameter int MAX_HOLD   = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req,
  input  logic [31:0] din,
  output logic [7:0]  gnt,
  output logic [2:0]  sel,
  output logic        en_n,
  output logic [3:0]  q,
  output logic [3:0]  qn,
  output logic        busy
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
  localparam logic [1:0] GAP_LAST = 2'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  gnt_q, gnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        en_n_q, en_n_d;
  logic        busy_q, busy_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [3:0]  hold_q, hold_d;
  logic [1:0]  gapcnt_q, gapcnt_d;

  logic [2:0]  arb_ptr;
  logic        win_found;
  logic [2:0]  win_idx;
  logic        release_now;

  // Scanning from the far end lets the entry closest to p win without an early exit.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Only a release from GRANT arbitrates in the same edge, and then ptr is already sel+1.
  assign arb_ptr     = (state_q == GRANT) ? sel_q + 3'd1 : ptr_q;
  assign {win_found, win_idx} = pick(req, arb_ptr);
  assign release_now = !req[sel_q] || (hold_q == HOLD_MAX);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    en_n_d   = en_n_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gapcnt_d = gapcnt_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = 8'(1) << win_idx;
          sel_d   = win_idx;
          en_n_d  = 1'b0;
          busy_d  = 1'b1;
          hold_d  = 4'd1;
        end
      end

      GRANT: begin
        if (release_now) begin
          ptr_d = sel_q + 3'd1;
          if (GAP_CYCLES > 0) begin
            state_d  = GAP;
            gnt_d    = 8'h00;
            en_n_d   = 1'b1;
            busy_d   = 1'b1;
            hold_d   = 4'd0;
            gapcnt_d = 2'd1;
          end else if (win_found) begin
            state_d = GRANT;
            gnt_d   = 8'(1) << win_idx;
            sel_d   = win_idx;
            en_n_d  = 1'b0;
            busy_d  = 1'b1;
            hold_d  = 4'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
            en_n_d  = 1'b1;
            busy_d  = 1'b0;
            hold_d  = 4'd0;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end

      GAP: begin
        if (gapcnt_q == GAP_LAST) begin
          gapcnt_d = 2'd0;
          if (win_found) begin
            state_d = GRANT;
            gnt_d   = 8'(1) << win_idx;
            sel_d   = win_idx;
            en_n_d  = 1'b0;
            busy_d  = 1'b1;
            hold_d  = 4'd1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gapcnt_d = gapcnt_q + 2'd1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
        en_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 8'h00;
      sel_q    <= 3'd0;
      en_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      ptr_q    <= 3'd0;
      hold_q   <= 4'd0;
      gapcnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      en_n_q   <= en_n_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      gapcnt_q <= gapcnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign en_n = en_n_q;
  assign busy = busy_q;
  assign q    = en_n_q ? 4'h0 : din[{sel_q, 2'b00} +: 4];
  assign qn   = ~q;

endmodule

// File: tb/tb_nibble_bus_arbiter.sv
// Directed bench for nibble_bus_arbiter: one instance without turnaround gap, one with a
// single-cycle gap, both holding each owner for at most four cycles.
module tb_nibble_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst0_n, rst1_n;
  logic [7:0]  req0, req1;
  logic [31:0] din0, din1;
  logic [7:0]  gnt0, gnt1;
  logic [2:0]  sel0, sel1;
  logic        en_n0, en_n1, busy0, busy1;
  logic [3:0]  q0, qn0, q1, qn1;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  nibble_bus_arbiter #(.MAX_HOLD(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .req(req0), .din(din0),
    .gnt(gnt0), .sel(sel0), .en_n(en_n0), .q(q0), .qn(qn0), .busy(busy0)
  );

  nibble_bus_arbiter #(.MAX_HOLD(4), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .req(req1), .din(din1),
    .gnt(gnt1), .sel(sel1), .en_n(en_n1), .q(q1), .qn(qn1), .busy(busy1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives one instance's reset/request for the next edge, then waits to the falling edge.
  task automatic applyStimulus(input bit which, input logic rst, input logic [7:0] rq);
    if (which) begin
      rst1_n = rst;
      req1   = rq;
    end else begin
      rst0_n = rst;
      req0   = rq;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pack0(input logic [7:0] g, input logic [2:0] s,
                                        input logic e, input logic [3:0] qq,
                                        input logic [3:0] qqn, input logic b);
    return {11'b0, g, s, e, qq, qqn, b};
  endfunction

  function automatic logic [31:0] pack1(input logic [7:0] g, input logic e,
                                        input logic [3:0] qq, input logic [3:0] qqn,
                                        input logic b);
    return {14'b0, g, e, qq, qqn, b};
  endfunction

  function automatic logic [31:0] obs0();
    return pack0(gnt0, sel0, en_n0, q0, qn0, busy0);
  endfunction

  function automatic logic [31:0] obs1();
    return pack1(gnt1, en_n1, q1, qn1, busy1);
  endfunction

  initial begin
    logic [2:0] owner;
    logic [3:0] nib;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    req0   = 8'hFF;
    req1   = 8'h20;
    din0   = 32'h76543210;
    din1   = 32'h00A00000;

    // Reset with every requester asserted, then release into full contention
    applyStimulus(0, 1'b0, 8'hFF);
    applyStimulus(0, 1'b0, 8'hFF);
    checkOutput("reset_dut0", obs0(), pack0(8'h00, 3'd0, 1'b1, 4'h0, 4'hF, 1'b0));
    checkOutput("reset_dut1", obs1(), pack1(8'h00, 1'b1, 4'h0, 4'hF, 1'b0));
    applyStimulus(0, 1'b1, 8'hFF);
    checkOutput("reset_release", obs0(), pack0(8'h01, 3'd0, 1'b0, 4'h0, 4'hF, 1'b1));

    for (int o = 0; o < 9; o++) begin
      for (int c = 0; c < 4; c++) begin
        owner = 3'(o % 8);
        nib   = {1'b0, owner};
        checkOutput("contention", obs0(),
                    pack0(8'(1) << owner, owner, 1'b0, nib, ~nib, 1'b1));
        applyStimulus(0, 1'b1, 8'hFF);
      end
    end

    // Early release of owner 3 hands directly to 6, skipping pending requester 2
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(0, 1'b1, 8'h08);
    checkOutput("owner3_c1", obs0(), pack0(8'h08, 3'd3, 1'b0, 4'h3, 4'hC, 1'b1));
    applyStimulus(0, 1'b1, 8'h4C);
    checkOutput("owner3_c2", obs0(), pack0(8'h08, 3'd3, 1'b0, 4'h3, 4'hC, 1'b1));
    applyStimulus(0, 1'b1, 8'h44);
    checkOutput("early_rel", obs0(), pack0(8'h40, 3'd6, 1'b0, 4'h6, 4'h9, 1'b1));
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, 1'b1, 8'h44);
      checkOutput("owner6_hold", obs0(), pack0(8'h40, 3'd6, 1'b0, 4'h6, 4'h9, 1'b1));
    end
    applyStimulus(0, 1'b1, 8'h44);
    checkOutput("rotate_to2", obs0(), pack0(8'h04, 3'd2, 1'b0, 4'h2, 4'hD, 1'b1));

    // Reset during the second grant cycle of owner 6
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(0, 1'b1, 8'h40);
    applyStimulus(0, 1'b1, 8'h40);
    checkOutput("mid_hold2", obs0(), pack0(8'h40, 3'd6, 1'b0, 4'h6, 4'h9, 1'b1));
    applyStimulus(0, 1'b0, 8'h40);
    checkOutput("mid_reset", obs0(), pack0(8'h00, 3'd0, 1'b1, 4'h0, 4'hF, 1'b0));
    applyStimulus(0, 1'b1, 8'h41);
    checkOutput("ptr_cleared", obs0(), pack0(8'h01, 3'd0, 1'b0, 4'h0, 4'hF, 1'b1));

    // Owner 7 releasing into an empty request set
    applyStimulus(0, 1'b0, 8'h00);
    applyStimulus(0, 1'b1, 8'h80);
    checkOutput("owner7", obs0(), pack0(8'h80, 3'd7, 1'b0, 4'h7, 4'h8, 1'b1));
    applyStimulus(0, 1'b1, 8'h00);
    checkOutput("idle_gnt", {24'b0, gnt0}, 32'h0);
    checkOutput("idle_flags", {22'b0, en_n0, busy0, q0, qn0}, {22'b0, 1'b1, 1'b0, 4'h0, 4'hF});
    applyStimulus(0, 1'b1, 8'h80);
    checkOutput("regrant7", obs0(), pack0(8'h80, 3'd7, 1'b0, 4'h7, 4'h8, 1'b1));
    applyStimulus(0, 1'b1, 8'h00);
    checkOutput("idle_again", {23'b0, gnt0, busy0}, 32'h0);
    applyStimulus(0, 1'b1, 8'h81);
    checkOutput("wrap_ptr0", obs0(), pack0(8'h01, 3'd0, 1'b0, 4'h0, 4'hF, 1'b1));

    // Single persistent requester with a one-cycle turnaround gap: period of five
    applyStimulus(1, 1'b1, 8'h20);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 5; c++) begin
        if (c < 4)
          checkOutput("gap_grant", obs1(), pack1(8'h20, 1'b0, 4'hA, 4'h5, 1'b1));
        else
          checkOutput("gap_idle", obs1(), pack1(8'h00, 1'b1, 4'h0, 4'hF, 1'b1));
        applyStimulus(1, 1'b1, 8'h20);
      end
    end
    checkOutput("gap_sel", {29'b0, sel1}, 32'd5);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
